// File: rtl/pwl_spf_rst_sched_pkg.sv
// Shared types and constants for the PWL filter reset scheduler.
package pwl_spf_sched_pkg;

  localparam int N_REQ_DEF = 2;
  localparam int GID_W     = $clog2(N_REQ_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ASSERT = 3'd1,
    HOLD   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwl_spf_rst_sched_if.sv
// Requester-side and filter-side signals of the reset scheduler.
interface pwl_spf_rst_sched_if #(
  parameter int N_REQ    = 2,
  parameter int CODE_W   = 8,
  parameter int HOLD_W   = 8,
  parameter int SETTLE_W = 12,
  parameter int GID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*CODE_W-1:0] req_code;
  logic [HOLD_W-1:0]       hold_cycles;
  logic [SETTLE_W-1:0]     settle_cycles;
  logic [N_REQ-1:0]        ack;
  logic                    flt_reset;
  logic [CODE_W-1:0]       flt_rst_code;
  logic                    busy;
  logic [GID_W-1:0]        grant_id;

  modport master (
    output req, req_code, hold_cycles, settle_cycles,
    input  ack, flt_reset, flt_rst_code, busy, grant_id
  );

  modport slave (
    input  req, req_code, hold_cycles, settle_cycles,
    output ack, flt_reset, flt_rst_code, busy, grant_id
  );

endinterface

// File: rtl/pwl_spf_rst_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int GID_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GID_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [GID_W-1:0] idx_o,
  output logic             valid_o
);

  localparam logic [GID_W:0] N_W = (GID_W+1)'(N_REQ);

  logic [N_REQ-1:0] rot_s;
  logic [GID_W:0]   sum_s;

  // Rotate so the pointer sits at bit 0, then scan downward so the lowest offset wins.
  always_comb begin
    rot_s   = N_REQ'({req_i, req_i} >> ptr_i);
    sum_s   = '0;
    valid_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        sum_s   = {1'b0, ptr_i} + (GID_W+1)'(k);
        valid_o = 1'b1;
      end else begin
        sum_s   = sum_s;
      end
    end
    if (sum_s >= N_W) begin
      sum_s = sum_s - N_W;
    end else begin
      sum_s = sum_s;
    end
    idx_o = sum_s[GID_W-1:0];
    gnt_o = valid_o ? (N_REQ'(1'b1) << idx_o) : '0;
  end

endmodule

// File: rtl/pwl_spf_rst_sched.sv
// Shares one PWL filter reset port between N_REQ requesters: force a coded
// level, hold it, release, let the filter settle, then acknowledge.
module pwl_spf_rst_sched
  import pwl_spf_sched_pkg::*;
#(
  parameter int                N_REQ     = 2,
  parameter int                CODE_W    = 8,
  parameter int                HOLD_W    = 8,
  parameter int                SETTLE_W  = 12,
  parameter logic [CODE_W-1:0] IDLE_CODE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  pwl_spf_rst_sched_if.slave   bus
);

  localparam int               GIDW    = gid_width(N_REQ);
  localparam int               CNT_W   = (HOLD_W > SETTLE_W) ? HOLD_W : SETTLE_W;
  localparam logic [GIDW-1:0]  LAST_ID = GIDW'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GIDW-1:0]     ptr_q, ptr_d;
  logic [GIDW-1:0]     gid_q, gid_d;
  logic [CODE_W-1:0]   code_lat_q, code_lat_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                flt_reset_q, flt_reset_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                busy_q, busy_d;

  logic [CODE_W-1:0]   codes_s [N_REQ];
  logic [CODE_W-1:0]   sel_code_s;
  logic [N_REQ-1:0]    arb_gnt_s;
  logic [GIDW-1:0]     arb_idx_s;
  logic                arb_valid_s;
  logic                req_g_s;
  logic [N_REQ-1:0]    grant_oh_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_codes
    assign codes_s[g] = bus.req_code[g*CODE_W +: CODE_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GID_W (GIDW)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  assign req_g_s    = bus.req[gid_q];
  assign grant_oh_s = N_REQ'(1'b1) << gid_q;

  // One-hot AND-OR select of the winning requester's code.
  always_comb begin
    sel_code_s = '0;
    for (int g = 0; g < N_REQ; g++) begin
      sel_code_s = sel_code_s | (codes_s[g] & {CODE_W{arb_gnt_s[g]}});
    end
  end

  // Next-state, counters and next output values; outputs follow the next state
  // so code and reset change on the very edge that enters a state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    code_lat_d = code_lat_q;
    hold_d     = hold_q;
    settle_d   = settle_q;
    ack_d      = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d    = ASSERT;
          gid_d      = arb_idx_s;
          code_lat_d = sel_code_s;
          hold_d     = bus.hold_cycles;
          settle_d   = bus.settle_cycles;
        end else begin
          state_d    = IDLE;
        end
      end
      ASSERT: begin
        if (!req_g_s) begin
          state_d = DONE;
        end else if (hold_q != '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(hold_q);
        end else if (settle_q != '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(settle_q);
        end else begin
          state_d = DONE;
          ack_d   = grant_oh_s;
        end
      end
      HOLD: begin
        if (!req_g_s) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_ONE) begin
          cnt_d   = cnt_q - CNT_ONE;
        end else if (settle_q != '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(settle_q);
        end else begin
          state_d = DONE;
          cnt_d   = '0;
          ack_d   = grant_oh_s;
        end
      end
      SETTLE: begin
        if (!req_g_s) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_ONE) begin
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          state_d = DONE;
          cnt_d   = '0;
          ack_d   = grant_oh_s;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + GIDW'(1'b1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    flt_reset_d = (state_d == ASSERT) || (state_d == HOLD);
    busy_d      = (state_d != IDLE);
    code_d      = (state_d == IDLE) ? IDLE_CODE : code_lat_d;
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gid_q       <= '0;
      code_lat_q  <= '0;
      hold_q      <= '0;
      settle_q    <= '0;
      ack_q       <= '0;
      flt_reset_q <= 1'b0;
      code_q      <= IDLE_CODE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      code_lat_q  <= code_lat_d;
      hold_q      <= hold_d;
      settle_q    <= settle_d;
      ack_q       <= ack_d;
      flt_reset_q <= flt_reset_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.flt_reset    = flt_reset_q;
  assign bus.flt_rst_code = code_q;
  assign bus.busy         = busy_q;
  assign bus.grant_id     = gid_q;

endmodule
